register_file: RTL and testbench
================================

Name: register_file

Overview:
- MIPS general-purpose register file: 2^ADDR_WIDTH words of DATA_WIDTH bits.
- Sits in the decode stage. Consumes rs/rt indices from the instruction decoder and the writeback result from WB.
- Drives the operand buses to the ALU / ID-EX stage.
- Each word is a bank of write-enabled, asynchronously cleared flip-flops.
- Register 0 is hardwired to zero.
- Optional same-cycle write-to-read bypass closes the WB→ID hazard.

Parameters:
- DATA_WIDTH, 32, bits per register.
- ADDR_WIDTH, 5, index width; register count = 2^ADDR_WIDTH (32).
- BYPASS, 1, 1 = forward write_data to a read port whose index matches the in-flight write; 0 = read returns stored value only.

Ports:
- clk  input  1  single clock; all writes on rising edge.
- reset  input  1  asynchronous, active-low reset; clears every register while low.
- read_reg1  input  ADDR_WIDTH  index for read port 1 (rs).
- read_reg2  input  ADDR_WIDTH  index for read port 2 (rt).
- write_reg  input  ADDR_WIDTH  destination index (rd/rt from WB).
- write_data  input  DATA_WIDTH  writeback value.
- reg_write  input  1  write enable from WB control.
- read_data1  output  DATA_WIDTH  operand for read_reg1.
- read_data2  output  DATA_WIDTH  operand for read_reg2.

Behaviour:
- Reset:
  - reset falling to 0 clears all registers to 0 immediately, with no clock needed.
  - While reset==0, writes are ignored and read_data1/2 = 0, with bypass suppressed.
  - Release (0→1) is synchronised by the system; the first write can occur on the first rising clk edge after release.
- Write:
  - On posedge clk with reset==1, reg_write==1 and write_reg!=0: reg[write_reg] <= write_data.
  - reg_write==0 holds all registers unchanged.
  - Write latency is 1 clock: a stored value is visible on the read port from the edge onward.
- Register 0:
  - Writes to index 0 are discarded.
  - Reads of index 0 always return 0, including under bypass.
  - Register 0 holds no storage flip-flops, or they are tied to 0.
- Read:
  - Combinational: read_data = reg[read_reg], zero-cycle latency from an index change.
  - Both ports are independent. The same index on both ports returns identical data.
- Bypass (BYPASS==1): when reset==1, reg_write==1, write_reg!=0 and write_reg==read_regN, read_dataN = write_data in the same cycle. Stored contents are still updated at the edge.
- Bypass (BYPASS==0): reads in the write cycle return the old value; the new value appears after the edge.
- Reset vs write: if reset is asserted in the same cycle as a pending write, reset wins and the register ends at 0.
- Widths: no arithmetic. write_data is stored verbatim; no sign extension or truncation.
- No X propagation: every register has a defined value after the first reset.

Test Plan:
- Reset: write 0xDEADBEEF to reg 8, drive reset=0 mid-cycle (no clk edge) → read_data1 for reg 8 = 0x00000000 immediately; all 32 regs read 0.
- Basic write/read: reg_write=1, write_reg=5, write_data=0x12345678, one edge; then read_reg1=5, read_reg2=5 → both read 0x12345678. With reg_write=0 and write_data=0xFFFFFFFF on the next edge, reg 5 still reads 0x12345678.
- Register 0: write 0xCAFEF00D to reg 0 with read_reg1=0 in the same cycle → read_data1=0 before and after the edge, under both BYPASS=1 and BYPASS=0.
- Bypass: BYPASS=1, reg 9=0x00000011, then in one cycle write_reg=9, write_data=0x00000022, read_reg2=9 → read_data2=0x00000022 before the edge. With BYPASS=0, read_data2=0x00000011 before the edge and 0x00000022 after.
- Full sweep: write reg i = i*0x01010101 for i=1..31 on consecutive edges, then read all pairs (i, 31-i) → exact values, reg 0 = 0, no aliasing between indices.
- Reset mid-operation: reg_write=1, write_reg=3, write_data=0xAAAA5555, reset low across the edge → reg 3 = 0 after reset release; the next write of 0x1 to reg 3 reads back 0x00000001.

Source files
------------

// File: rtl/register_file.sv
// MIPS general-purpose register file: two combinational read ports, one clocked
// write port, register 0 hardwired to zero, optional same-cycle WB->ID bypass.
module register_file #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter bit          BYPASS     = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] read_reg1,
   input  logic [ADDR_WIDTH-1:0] read_reg2,
   input  logic [ADDR_WIDTH-1:0] write_reg,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  reg_write,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2
);

   localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regBank [NUM_REGS];
   logic                  writeEn;
   logic                  fwd1;
   logic                  fwd2;

   // Index 0 is never a legal destination, so its entry only ever holds the reset value.
   assign writeEn = reg_write && (write_reg != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regBank[i] <= '0;
         end
      end else if (writeEn) begin
         regBank[write_reg] <= write_data;
      end
   end

   assign fwd1 = BYPASS && writeEn && (write_reg == read_reg1);
   assign fwd2 = BYPASS && writeEn && (write_reg == read_reg2);

   // Reads are zero while in reset and for index 0; forwarding only applies to live writes.
   always_comb begin
      read_data1 = '0;
      read_data2 = '0;
      if (reset) begin
         if (read_reg1 != '0) begin
            read_data1 = fwd1 ? write_data : regBank[read_reg1];
         end
         if (read_reg2 != '0) begin
            read_data2 = fwd2 ? write_data : regBank[read_reg2];
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: runs a bypassing and a non-bypassing register file side by side
// against an array-based reference model of the MIPS register file.
module tb_register_file;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;
   localparam int unsigned NR = 32;

   typedef struct {
      string      name;
      logic [DW-1:0] e1b;
      logic [DW-1:0] e2b;
      logic [DW-1:0] e1n;
      logic [DW-1:0] e2n;
   } expect_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] read_reg1, read_reg2, write_reg;
   logic [DW-1:0] write_data;
   logic          reg_write;
   logic [DW-1:0] rd1B, rd2B, rd1N, rd2N;

   logic [DW-1:0] model [NR];
   expect_t       sbq [$];
   event          sampleEv;
   int            nCompared = 0;
   int            nMismatched = 0;

   always #5 clk = ~clk;

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1)) dutB (
      .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
      .read_data1(rd1B), .read_data2(rd2B));

   register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0)) dutN (
      .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
      .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
      .read_data1(rd1N), .read_data2(rd2N));

   // Architectural read rule: zero in reset or for r0, else forwarded or stored value.
   function automatic logic [DW-1:0] refRead(input int idx, input bit byp);
      if (reset !== 1'b1 || idx == 0) return '0;
      if (byp && reg_write && int'(write_reg) == idx && write_reg != 0) return write_data;
      return model[idx];
   endfunction

   task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: whenever the outputs are presented for sampling, pop and compare.
   initial begin
      expect_t e;
      forever begin
         @(sampleEv);
         if (sbq.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL scoreboard_underflow at %0t", $time);
         end else begin
            e = sbq.pop_front();
            cmp({e.name, " rd1 byp"},   rd1B, e.e1b);
            cmp({e.name, " rd2 byp"},   rd2B, e.e2b);
            cmp({e.name, " rd1 nobyp"}, rd1N, e.e1n);
            cmp({e.name, " rd2 nobyp"}, rd2N, e.e2n);
         end
      end
   end

   task automatic probe(input string nm, input int r1, input int r2);
      expect_t e;
      read_reg1 = AW'(r1);
      read_reg2 = AW'(r2);
      #1;
      e.name = nm;
      e.e1b = refRead(r1, 1'b1);
      e.e2b = refRead(r2, 1'b1);
      e.e1n = refRead(r1, 1'b0);
      e.e2n = refRead(r2, 1'b0);
      sbq.push_back(e);
      -> sampleEv;
      #1;
   endtask

   // One clock edge; the model commits the write that is pending at the edge.
   task automatic edgeStep();
      bit            doW;
      int            wr;
      logic [DW-1:0] wd;
      @(posedge clk);
      doW = (reset === 1'b1) && reg_write && write_reg != 0;
      wr  = int'(write_reg);
      wd  = write_data;
      if (doW) model[wr] = wd;
      @(negedge clk);
   endtask

   task automatic setWrite(input bit we, input int wr, input logic [DW-1:0] wd);
      reg_write  = we;
      write_reg  = AW'(wr);
      write_data = wd;
   endtask

   task automatic assertReset();
      reset = 1'b0;
      foreach (model[i]) model[i] = '0;
   endtask

   initial begin
      int r1, r2, wr;
      foreach (model[i]) model[i] = '0;
      read_reg1 = '0; read_reg2 = '0;
      setWrite(1'b0, 0, '0);
      assertReset();
      repeat (2) @(negedge clk);
      probe("reset_state", 8, 31);
      reset = 1'b1;
      @(negedge clk);

      // Async reset clears without a clock edge
      setWrite(1'b1, 8, 32'hDEADBEEF);
      edgeStep();
      setWrite(1'b0, 0, '0);
      probe("r8_written", 8, 8);
      #2;
      assertReset();
      probe("async_reset_r8", 8, 8);
      for (int i = 0; i < NR; i += 2) probe("reset_all", i, i + 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Basic write / hold
      setWrite(1'b1, 5, 32'h12345678);
      edgeStep();
      setWrite(1'b0, 5, 32'hFFFFFFFF);
      probe("basic_rd", 5, 5);
      edgeStep();
      probe("basic_hold", 5, 5);

      // Register 0 discards writes, reads zero even under bypass
      setWrite(1'b1, 0, 32'hCAFEF00D);
      probe("r0_before", 0, 0);
      edgeStep();
      probe("r0_after", 0, 0);

      // Bypass vs no bypass on reg 9
      setWrite(1'b1, 9, 32'h00000011);
      edgeStep();
      setWrite(1'b1, 9, 32'h00000022);
      probe("bypass_before", 5, 9);
      edgeStep();
      setWrite(1'b0, 0, '0);
      probe("bypass_after", 5, 9);

      // Full sweep
      for (int i = 1; i < NR; i++) begin
         setWrite(1'b1, i, DW'(i) * 32'h01010101);
         edgeStep();
      end
      setWrite(1'b0, 0, '0);
      for (int i = 0; i < NR; i++) probe("sweep", i, NR - 1 - i);

      // Reset held low across a pending write
      setWrite(1'b1, 3, 32'hAAAA5555);
      assertReset();
      edgeStep();
      reset = 1'b1;
      setWrite(1'b0, 0, '0);
      probe("reset_vs_write", 3, 31);
      setWrite(1'b1, 3, 32'h00000001);
      edgeStep();
      setWrite(1'b0, 0, '0);
      probe("after_reset_write", 3, 3);

      // Randomized traffic with deliberate index collisions
      for (int n = 0; n < 400; n++) begin
         wr = int'($urandom_range(0, NR - 1));
         r1 = ($urandom_range(0, 3) == 0) ? wr : int'($urandom_range(0, NR - 1));
         r2 = ($urandom_range(0, 3) == 0) ? wr : int'($urandom_range(0, NR - 1));
         setWrite(bit'($urandom_range(0, 1)), wr, DW'($urandom));
         probe("random", r1, r2);
         edgeStep();
      end
      setWrite(1'b0, 0, '0);
      for (int i = 0; i < NR; i++) probe("final_dump", i, i);

      // Drain check
      for (int k = 0; k < 10 && sbq.size() != 0; k++) #1;
      if (sbq.size() != 0) begin
         nCompared++;
         nMismatched++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
